// File: rtl/uart_loader.sv
// uart_loader: interprets a UART byte stream as W/R/H/X commands, runs byte-wide
// memory bus cycles and returns acknowledge, error, timeout or read-data bytes.
module uart_loader #(
  parameter int unsigned TIMEOUT   = 255,
  parameter bit          HOLD_INIT = 1'b1,
  parameter logic [7:0]  ACK_CHR   = 8'h2E,
  parameter logic [7:0]  ERR_CHR   = 8'h3F,
  parameter logic [7:0]  TMO_CHR   = 8'h21
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_dat_i,
  input  logic        rx_stb_i,
  output logic [7:0]  tx_dat_o,
  output logic        tx_stb_o,
  input  logic        tx_rdy_i,
  output logic [15:0] mem_adr_o,
  output logic [7:0]  mem_dat_o,
  input  logic [7:0]  mem_dat_i,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  input  logic        mem_ack_i,
  output logic        hold_o,
  output logic        ovr_o,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADRH, S_ADRL, S_LEN, S_WDAT, S_WBUS, S_RBUS, S_RSEND, S_RESP
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_wr;
  logic [8:0]  r_cnt;
  logic [15:0] r_tmo;
  logic [15:0] r_adr;
  logic [7:0]  r_wdat;
  logic [7:0]  r_txd;
  logic        r_txs;
  logic        r_cyc;
  logic        r_we;
  logic        r_hold;
  logic        r_ovr;

  logic        w_rx_drop;
  logic        w_last;

  // Bytes arriving while a bus cycle or transmit is pending cannot be buffered.
  assign w_rx_drop = rx_stb_i && (r_state == S_WBUS || r_state == S_RBUS ||
                                  r_state == S_RSEND || r_state == S_RESP);
  assign w_last    = (r_cnt == 9'd1);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_cnt   <= 9'd0;
      r_tmo   <= 16'd0;
      r_adr   <= 16'd0;
      r_wdat  <= 8'd0;
      r_txd   <= 8'd0;
      r_txs   <= 1'b0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_hold  <= HOLD_INIT;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= w_rx_drop;
      case (r_state)
        S_IDLE: begin
          if (rx_stb_i) begin
            case (rx_dat_i)
              8'h57: begin r_wr <= 1'b1; r_state <= S_ADRH; end
              8'h52: begin r_wr <= 1'b0; r_state <= S_ADRH; end
              8'h48: begin
                r_hold  <= 1'b1;
                r_txd   <= ACK_CHR;
                r_txs   <= 1'b1;
                r_state <= S_RESP;
              end
              8'h58: begin
                r_hold  <= 1'b0;
                r_txd   <= ACK_CHR;
                r_txs   <= 1'b1;
                r_state <= S_RESP;
              end
              default: begin
                r_txd   <= ERR_CHR;
                r_txs   <= 1'b1;
                r_state <= S_RESP;
              end
            endcase
          end
        end
        S_ADRH: begin
          if (rx_stb_i) begin
            r_adr[15:8] <= rx_dat_i;
            r_state     <= S_ADRL;
          end
        end
        S_ADRL: begin
          if (rx_stb_i) begin
            r_adr[7:0] <= rx_dat_i;
            r_state    <= S_LEN;
          end
        end
        S_LEN: begin
          if (rx_stb_i) begin
            r_cnt   <= (rx_dat_i == 8'd0) ? 9'd256 : {1'b0, rx_dat_i};
            r_state <= r_wr ? S_WDAT : S_RBUS;
          end
        end
        S_WDAT: begin
          if (rx_stb_i) begin
            r_wdat  <= rx_dat_i;
            r_state <= S_WBUS;
          end
        end
        S_WBUS, S_RBUS: begin
          // First cycle in the state is the mandatory bus idle cycle.
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_we  <= (r_state == S_WBUS);
            r_tmo <= 16'd0;
          end else if (mem_ack_i) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            if (r_state == S_WBUS) begin
              r_adr <= r_adr + 16'd1;
              r_cnt <= r_cnt - 9'd1;
              if (w_last) begin
                r_txd   <= ACK_CHR;
                r_txs   <= 1'b1;
                r_state <= S_RESP;
              end else begin
                r_state <= S_WDAT;
              end
            end else begin
              r_txd   <= mem_dat_i;
              r_txs   <= 1'b1;
              r_state <= S_RSEND;
            end
          end else if (r_tmo == TMO_LAST) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_cnt   <= 9'd0;
            r_txd   <= TMO_CHR;
            r_txs   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        S_RSEND: begin
          if (tx_rdy_i) begin
            r_txs   <= 1'b0;
            r_adr   <= r_adr + 16'd1;
            r_cnt   <= r_cnt - 9'd1;
            r_state <= w_last ? S_IDLE : S_RBUS;
          end
        end
        S_RESP: begin
          if (tx_rdy_i) begin
            r_txs   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_dat_o  = r_txd;
  assign tx_stb_o  = r_txs;
  assign mem_adr_o = r_adr;
  assign mem_dat_o = r_wdat;
  assign mem_cyc_o = r_cyc;
  assign mem_stb_o = r_cyc;
  assign mem_we_o  = r_we;
  assign hold_o    = r_hold;
  assign ovr_o     = r_ovr;
  assign busy_o    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: randomized command streams against a byte-level model of the loader
// (reference memory image, expected bus accesses and expected transmit bytes).
`timescale 1ns/1ps
module tb_uart_loader;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_dat = 8'd0;
  logic        rx_stb = 1'b0;
  logic [7:0]  tx_dat_o;
  logic        tx_stb_o;
  logic        tx_rdy_i = 1'b0;
  logic [15:0] mem_adr_o;
  logic [7:0]  mem_dat_o;
  logic [7:0]  mem_dat_i = 8'd0;
  logic        mem_cyc_o, mem_stb_o, mem_we_o;
  logic        mem_ack_i = 1'b0;
  logic        hold_o, ovr_o, busy_o;

  always #5 clk = ~clk;

  uart_loader #(.TIMEOUT(TMO), .HOLD_INIT(1'b1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .rx_dat_i(rx_dat), .rx_stb_i(rx_stb),
    .tx_dat_o(tx_dat_o), .tx_stb_o(tx_stb_o), .tx_rdy_i(tx_rdy_i),
    .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
    .mem_ack_i(mem_ack_i), .hold_o(hold_o), .ovr_o(ovr_o), .busy_o(busy_o)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  bus_mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  tx_q [$];
  logic [15:0] acc_adr_q [$];
  logic        acc_we_q [$];
  logic [7:0]  acc_dat_q [$];
  bit          slave_en = 1'b1;
  int          rdy_mode = 0;
  int          stb_cycles = 0, cyc_rises = 0, bus_viol = 0, tx_viol = 0, ovr_cnt = 0;
  logic        exp_hold = 1'b1;

  task automatic slave_proc();
    int wait_n = 0;
    forever begin
      @(negedge clk);
      if (mem_ack_i) mem_ack_i = 1'b0;
      else if (slave_en && mem_cyc_o && mem_stb_o) begin
        if (wait_n == 0) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) bus_mem[mem_adr_o] = mem_dat_o;
          else mem_dat_i = bus_mem[mem_adr_o];
          acc_adr_q.push_back(mem_adr_o);
          acc_we_q.push_back(mem_we_o);
          acc_dat_q.push_back(mem_we_o ? mem_dat_o : bus_mem[mem_adr_o]);
          wait_n = $urandom_range(0, 4);
        end else wait_n--;
      end
    end
  endtask

  task automatic sink_proc();
    bit prev_wait = 1'b0;
    bit pstb = 1'b0, pcyc = 1'b0, pwe = 1'b0;
    logic [7:0] ptx = 8'd0, pd = 8'd0;
    logic [15:0] padr = 16'd0, pa = 16'd0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: tx_rdy_i = 1'b1;
        1: tx_rdy_i = 1'($urandom_range(0, 1));
        default: tx_rdy_i = 1'b0;
      endcase
      if (prev_wait && tx_stb_o && (tx_dat_o !== ptx || mem_adr_o !== padr)) tx_viol++;
      if (tx_stb_o && tx_rdy_i) tx_q.push_back(tx_dat_o);
      prev_wait = tx_stb_o && !tx_rdy_i;
      ptx = tx_dat_o;
      padr = mem_adr_o;
      if (mem_stb_o) stb_cycles++;
      if (mem_cyc_o && !pcyc) cyc_rises++;
      if (mem_stb_o && pstb && (mem_adr_o !== pa || mem_we_o !== pwe || mem_dat_o !== pd)) bus_viol++;
      if (ovr_o) ovr_cnt++;
      pstb = mem_stb_o; pcyc = mem_cyc_o; pwe = mem_we_o; pa = mem_adr_o; pd = mem_dat_o;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_dat = b;
    rx_stb = 1'b1;
    @(negedge clk);
    rx_stb = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy_o) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic clear_logs();
    tx_q = {}; acc_adr_q = {}; acc_we_q = {}; acc_dat_q = {};
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_stb = 1'b1; rx_dat = 8'h48;
    repeat (3) @(negedge clk);
    n_vec++; if (hold_o !== 1'b1) begin n_err++; $display("FAIL rst_hold: got %b want 1", hold_o); end
    n_vec++; if ({mem_cyc_o, mem_stb_o, mem_we_o} !== 3'b000) begin n_err++; $display("FAIL rst_bus: got %b want 000", {mem_cyc_o, mem_stb_o, mem_we_o}); end
    n_vec++; if ({tx_stb_o, ovr_o, busy_o} !== 3'b000) begin n_err++; $display("FAIL rst_ctl: got %b want 000", {tx_stb_o, ovr_o, busy_o}); end
    n_vec++; if ({mem_adr_o, mem_dat_o, tx_dat_o} !== 32'd0) begin n_err++; $display("FAIL rst_data: got %h want 0", {mem_adr_o, mem_dat_o, tx_dat_o}); end
    rst = 1'b0; rx_stb = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if ({busy_o, tx_stb_o} !== 2'b00) begin n_err++; $display("FAIL rst_rx_ignored: got %b want 00", {busy_o, tx_stb_o}); end
  endtask

  task automatic test_write_read();
    logic [7:0] d [$];
    logic [15:0] a, ea;
    int n;
    bit to;
    for (int t = 0; t < 4; t++) begin
      if (t == 0) begin a = 16'h1234; d = '{8'hAA, 8'hBB, 8'hCC}; end
      else begin
        a = 16'($urandom); n = $urandom_range(1, 6); d = {};
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      end
      clear_logs(); bus_viol = 0;
      rdy_mode = (t == 0) ? 0 : 1;
      send_byte(8'h57, 2); send_byte(a[15:8], 2); send_byte(a[7:0], 2); send_byte(8'(d.size()), 2);
      foreach (d[i]) send_byte(d[i], 12);
      wait_idle(200, to);
      foreach (d[i]) ref_mem[16'(a + i)] = d[i];
      n_vec++; if (to) begin n_err++; $display("FAIL wr_done t%0d: busy still 1 want 0", t); end
      n_vec++; if (acc_adr_q.size() !== d.size()) begin n_err++; $display("FAIL wr_count t%0d: got %0d want %0d", t, acc_adr_q.size(), d.size()); end
      for (int i = 0; i < d.size() && i < acc_adr_q.size(); i++) begin
        ea = 16'(a + i);
        n_vec++; if ({acc_adr_q[i], acc_we_q[i], acc_dat_q[i]} !== {ea, 1'b1, d[i]}) begin n_err++; $display("FAIL wr_acc t%0d[%0d]: got %h/%b/%h want %h/1/%h", t, i, acc_adr_q[i], acc_we_q[i], acc_dat_q[i], ea, d[i]); end
      end
      n_vec++; if (tx_q.size() !== 1 || tx_q[0] !== 8'h2E) begin n_err++; $display("FAIL wr_resp t%0d: got %0d bytes first %h want 1 byte 2e", t, tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00); end
      clear_logs();
      send_byte(8'h52, 2); send_byte(a[15:8], 2); send_byte(a[7:0], 2); send_byte(8'(d.size()), 0);
      wait_idle(300, to);
      n_vec++; if (to || tx_q.size() !== d.size()) begin n_err++; $display("FAIL rd_count t%0d: got %0d bytes want %0d", t, tx_q.size(), d.size()); end
      for (int i = 0; i < d.size() && i < tx_q.size(); i++) begin
        n_vec++; if (tx_q[i] !== ref_mem[16'(a + i)]) begin n_err++; $display("FAIL rd_data t%0d[%0d]: got %h want %h", t, i, tx_q[i], ref_mem[16'(a + i)]); end
      end
      n_vec++; if (bus_viol !== 0) begin n_err++; $display("FAIL bus_stable t%0d: got %0d changes want 0", t, bus_viol); end
    end
  endtask

  task automatic test_wrap();
    bit to;
    int bad = 0;
    clear_logs(); bus_viol = 0; rdy_mode = 1;
    send_byte(8'h52, 2); send_byte(8'hFF, 2); send_byte(8'hFF, 2); send_byte(8'h00, 0);
    wait_idle(8000, to);
    n_vec++; if (to) begin n_err++; $display("FAIL wrap_done: busy still 1 want 0"); end
    n_vec++; if (tx_q.size() !== 256) begin n_err++; $display("FAIL wrap_txcount: got %0d want 256", tx_q.size()); end
    n_vec++; if (acc_adr_q.size() !== 256) begin n_err++; $display("FAIL wrap_acccount: got %0d want 256", acc_adr_q.size()); end
    for (int i = 0; i < 256 && i < tx_q.size(); i++) begin
      n_vec++; if (tx_q[i] !== ref_mem[16'(16'hFFFF + i)]) begin n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", i, tx_q[i], ref_mem[16'(16'hFFFF + i)]); end
    end
    for (int i = 0; i < 256 && i < acc_adr_q.size(); i++)
      if (acc_adr_q[i] !== 16'(16'hFFFF + i) || acc_we_q[i] !== 1'b0) bad++;
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL wrap_addr: got %0d wrong accesses want 0", bad); end
    n_vec++; if (bus_viol !== 0) begin n_err++; $display("FAIL wrap_stable: got %0d want 0", bus_viol); end
  endtask

  task automatic test_timeout();
    bit to;
    clear_logs(); rdy_mode = 0; slave_en = 1'b0;
    stb_cycles = 0; cyc_rises = 0;
    send_byte(8'h52, 2); send_byte(8'h00, 2); send_byte(8'h10, 2); send_byte(8'h02, 0);
    wait_idle(100, to);
    repeat (10) @(negedge clk);
    n_vec++; if (to) begin n_err++; $display("FAIL tmo_done: busy still 1 want 0"); end
    n_vec++; if (stb_cycles !== TMO) begin n_err++; $display("FAIL tmo_stb_cycles: got %0d want %0d", stb_cycles, TMO); end
    n_vec++; if (cyc_rises !== 1) begin n_err++; $display("FAIL tmo_accesses: got %0d want 1", cyc_rises); end
    n_vec++; if (tx_q.size() !== 1 || tx_q[0] !== 8'h21) begin n_err++; $display("FAIL tmo_resp: got %0d bytes first %h want 1 byte 21", tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00); end
    n_vec++; if (hold_o !== exp_hold) begin n_err++; $display("FAIL tmo_hold: got %b want %b", hold_o, exp_hold); end
    slave_en = 1'b1;
  endtask

  task automatic test_commands();
    logic [7:0] cmd, exp_c;
    bit to;
    rdy_mode = 1;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: cmd = 8'h58;
        1: cmd = 8'h48;
        2: cmd = 8'h5A;
        default: begin
          cmd = 8'($urandom);
          while (cmd == 8'h57 || cmd == 8'h52 || cmd == 8'h48 || cmd == 8'h58) cmd = 8'($urandom);
        end
      endcase
      if (cmd == 8'h58) begin exp_hold = 1'b0; exp_c = 8'h2E; end
      else if (cmd == 8'h48) begin exp_hold = 1'b1; exp_c = 8'h2E; end
      else exp_c = 8'h3F;
      clear_logs();
      send_byte(cmd, 0);
      wait_idle(50, to);
      n_vec++; if (to || tx_q.size() !== 1 || tx_q[0] !== exp_c) begin n_err++; $display("FAIL cmd_resp %h: got %0d bytes first %h want %h", cmd, tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00, exp_c); end
      n_vec++; if (hold_o !== exp_hold) begin n_err++; $display("FAIL cmd_hold %h: got %b want %b", cmd, hold_o, exp_hold); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a, a0;
    logic [7:0] d0;
    int ovr0, waited;
    bit to;
    a = 16'($urandom);
    clear_logs(); tx_viol = 0; rdy_mode = 2;
    send_byte(8'h52, 2); send_byte(a[15:8], 2); send_byte(a[7:0], 2); send_byte(8'h02, 0);
    waited = 0;
    while (!tx_stb_o && waited < 50) begin @(negedge clk); waited++; end
    n_vec++; if (tx_stb_o !== 1'b1) begin n_err++; $display("FAIL bp_stb: got %b want 1", tx_stb_o); end
    d0 = tx_dat_o; a0 = mem_adr_o; ovr0 = ovr_cnt;
    n_vec++; if (d0 !== ref_mem[a]) begin n_err++; $display("FAIL bp_first: got %h want %h", d0, ref_mem[a]); end
    send_byte(8'($urandom), 0);
    repeat (20) @(negedge clk);
    n_vec++; if (tx_dat_o !== ref_mem[a] || mem_adr_o !== a || tx_stb_o !== 1'b1) begin n_err++; $display("FAIL bp_stable: got %h@%h stb %b want %h@%h stb 1", tx_dat_o, mem_adr_o, tx_stb_o, ref_mem[a], a); end
    n_vec++; if (tx_viol !== 0) begin n_err++; $display("FAIL bp_hold_viol: got %0d want 0", tx_viol); end
    n_vec++; if (ovr_cnt - ovr0 !== 1) begin n_err++; $display("FAIL bp_ovr: got %0d pulse cycles want 1", ovr_cnt - ovr0); end
    rdy_mode = 0;
    wait_idle(100, to);
    n_vec++; if (to || tx_q.size() !== 2) begin n_err++; $display("FAIL bp_count: got %0d want 2", tx_q.size()); end
    n_vec++; if (tx_q.size() == 2 && (tx_q[0] !== ref_mem[a] || tx_q[1] !== ref_mem[16'(a + 1)])) begin n_err++; $display("FAIL bp_data: got %h %h want %h %h", tx_q[0], tx_q[1], ref_mem[a], ref_mem[16'(a + 1)]); end
  endtask

  task automatic test_reset_mid_write();
    int waited;
    bit to;
    rdy_mode = 0;
    clear_logs();
    send_byte(8'h58, 0);
    wait_idle(50, to);
    exp_hold = 1'b0;
    n_vec++; if (hold_o !== 1'b0) begin n_err++; $display("FAIL rmw_prehold: got %b want 0", hold_o); end
    slave_en = 1'b0;
    send_byte(8'h57, 2); send_byte(8'h00, 2); send_byte(8'h40, 2); send_byte(8'h02, 2); send_byte(8'hD1, 0);
    waited = 0;
    while (!mem_stb_o && waited < 20) begin @(negedge clk); waited++; end
    n_vec++; if (mem_stb_o !== 1'b1 || mem_we_o !== 1'b1) begin n_err++; $display("FAIL rmw_inbus: got stb %b we %b want 1 1", mem_stb_o, mem_we_o); end
    rst = 1'b1;
    @(negedge clk);
    exp_hold = 1'b1;
    n_vec++; if ({mem_cyc_o, mem_stb_o, mem_we_o, tx_stb_o, busy_o} !== 5'b0) begin n_err++; $display("FAIL rmw_ctl: got %b want 00000", {mem_cyc_o, mem_stb_o, mem_we_o, tx_stb_o, busy_o}); end
    n_vec++; if (hold_o !== exp_hold) begin n_err++; $display("FAIL rmw_hold: got %b want %b", hold_o, exp_hold); end
    rst = 1'b0; slave_en = 1'b1;
    clear_logs();
    send_byte(8'h52, 2); send_byte(8'h00, 2); send_byte(8'h00, 2); send_byte(8'h01, 0);
    wait_idle(100, to);
    n_vec++; if (to || tx_q.size() !== 1 || tx_q[0] !== ref_mem[16'h0000]) begin n_err++; $display("FAIL rmw_read: got %0d bytes first %h want 1 byte %h", tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00, ref_mem[16'h0000]); end
    n_vec++; if (acc_adr_q.size() !== 1 || bus_mem[16'h0040] !== ref_mem[16'h0040]) begin n_err++; $display("FAIL rmw_nowrite: got %0d accesses mem40 %h want 1 access mem40 %h", acc_adr_q.size(), bus_mem[16'h0040], ref_mem[16'h0040]); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    fork
      slave_proc();
      sink_proc();
    join_none
    test_reset();
    test_write_read();
    test_wrap();
    test_timeout();
    test_commands();
    test_backpressure();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Serial command interpreter and bus initiator; the host-side counterpart to the UART peripheral.
- Consumes the byte stream from a UART receiver.
- Issues byte-wide memory read/write cycles to the system RAM/peripheral bus.
- Returns responses through a UART transmitter byte port.
- Gives board-level debug/program download into RAM and can hold the CPU in reset while loading.

Parameters:
- TIMEOUT, 255: bus cycles to wait for mem_ack_i before aborting a transfer (1..65535).
- HOLD_INIT, 1: value of hold_o after reset.
- ACK_CHR, 8'h2E: response byte for successful W/H/X commands ('.').
- ERR_CHR, 8'h3F: response byte for an unknown command ('?').
- TMO_CHR, 8'h21: response byte for a bus timeout ('!').

Ports:
- wb_clk_i  in  1  system clock; all logic on its rising edge.
- wb_rst_i  in  1  synchronous active-high reset.
- rx_dat_i  in  8  received byte.
- rx_stb_i  in  1  one-cycle strobe, rx_dat_i valid; no backpressure.
- tx_dat_o  out 8  byte to transmit.
- tx_stb_o  out 1  tx byte valid; held with tx_dat_o stable until accepted.
- tx_rdy_i  in  1  transmitter accepts byte when tx_stb_o & tx_rdy_i.
- mem_adr_o out 16 bus address.
- mem_dat_o out 8  write data.
- mem_dat_i in  8  read data, sampled on mem_ack_i.
- mem_cyc_o out 1  bus cycle active.
- mem_stb_o out 1  bus strobe.
- mem_we_o  out 1  1 = write.
- mem_ack_i in  1  bus acknowledge.
- hold_o    out 1  CPU reset hold request (1 = hold).
- ovr_o     out 1  one-cycle pulse: received byte dropped.
- busy_o    out 1  state != IDLE.

Behaviour:
- Reset values (wb_rst_i sampled high on any edge, including mid-operation):
  - state IDLE.
  - mem_cyc_o = mem_stb_o = mem_we_o = 0 on the next edge.
  - tx_stb_o = 0; ovr_o = 0; busy_o = 0.
  - mem_adr_o = 0, mem_dat_o = 0, tx_dat_o = 0.
  - hold_o = HOLD_INIT.
  - Any in-flight bus cycle or response is abandoned without reporting.
- Command set (first byte in IDLE):
  - 'W' (8'h57) addrH addrL len data[len]: write len bytes.
  - 'R' (8'h52) addrH addrL len: read len bytes.
  - 'H' (8'h48): hold_o <= 1, respond ACK_CHR.
  - 'X' (8'h58): hold_o <= 0, respond ACK_CHR.
  - Any other byte: respond ERR_CHR.
- Length and address rules:
  - len = 0 means 256 bytes; internal 9-bit counter.
  - Address increments by 1 after each completed byte and wraps FFFF -> 0000.
- States:
  - IDLE: decode command byte.
  - ADRH / ADRL / LEN: collect header bytes, one per rx_stb_i.
  - After LEN: 'W' -> WDAT; 'R' -> RBUS.
  - WDAT: wait for data byte, latch into mem_dat_o, go to WBUS.
  - WBUS: cyc = stb = we = 1 until mem_ack_i.
    - On the ack edge, drop cyc/stb/we, increment address, decrement count.
    - count 0 -> RESP(ACK_CHR); else -> WDAT.
  - RBUS: cyc = stb = 1, we = 0 until mem_ack_i.
    - On the ack edge, latch mem_dat_i into tx_dat_o and go to RSEND.
  - RSEND: tx_stb_o = 1 until tx_rdy_i.
    - On the accept edge, increment address, decrement count.
    - count 0 -> IDLE (no trailer byte); else -> RBUS.
  - RESP: tx_stb_o = 1 with the response byte until tx_rdy_i, then -> IDLE.
- Bus timing:
  - mem_cyc_o/stb_o assert on the edge after entering WBUS/RBUS.
  - An ack in the first strobe cycle completes the access.
  - Minimum 1 idle cycle between consecutive accesses.
  - mem_adr_o/dat_o/we_o are stable for the entire strobe.
- Timeout:
  - A 16-bit counter is cleared on entry to WBUS/RBUS and increments every strobe cycle.
  - Reaching TIMEOUT without ack: drop cyc/stb, go to RESP(TMO_CHR), abort the remaining count.
  - An ack in the same cycle as the limit counts as success.
- Overrun:
  - An rx_stb_i in any state other than IDLE/ADRH/ADRL/LEN/WDAT (WBUS, RBUS, RSEND, RESP) drops the byte.
  - ovr_o pulses high for 1 cycle and the state is unaffected.
  - rx_stb_i together with reset is ignored.
- hold_o changes only on H/X decode or reset; it is unaffected by W/R or timeouts.
- tx_dat_o must not change while tx_stb_o = 1 and tx_rdy_i = 0.

Test Plan:
- Write, then read back: send 57 12 34 03 AA BB CC, then 52 12 34 03 -> writes AA@1234, BB@1235, CC@1236 with we=1; tx emits 2E; then tx emits AA BB CC, no trailer.
- len 0 with address wrap: 52 FF FF 00 -> 256 reads at FFFF, 0000, ..., 00FE; exactly 256 tx bytes; busy_o falls after the last byte is accepted.
- Bus timeout: TIMEOUT=8, mem_ack_i held 0, send 52 00 10 02 -> stb high for 8 cycles, then cyc/stb low, tx emits 21 once, no second access.
- Commands and errors: after reset hold_o=1; 58 -> hold_o=0 and tx 2E; 48 -> hold_o=1 and tx 2E; 5A -> tx 3F with hold_o unchanged.
- Backpressure and overrun: tx_rdy_i low 20 cycles during RSEND -> tx_dat_o stable, no address advance; an rx byte injected during RSEND -> ovr_o pulse, read sequence intact.
- Reset mid-write: assert wb_rst_i while in WBUS -> next edge cyc/stb/we=0, tx_stb_o=0, hold_o=HOLD_INIT; a following 52 00 00 01 works normally.
